// File: rtl/cordic_vectoring.sv
// Iterative vectoring-mode CORDIC: converts a signed (x,y) vector to a
// gain-compensated magnitude and a 32-bit binary angle, one micro-rotation per clock.
`timescale 1ns/1ps

module cordic_vectoring #(
    parameter int WIDTH = 16,
    parameter int ITERS = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic signed [WIDTH-1:0] x_in,
    input  logic signed [WIDTH-1:0] y_in,
    output logic                    busy,
    output logic                    done,
    output logic        [WIDTH:0]   mag,
    output logic        [31:0]      angle
);

    localparam int IW = WIDTH + 2;
    localparam int MW = WIDTH + 1;
    localparam int CW = (ITERS > 1) ? $clog2(ITERS) : 1;

    localparam logic signed [31:0] ATAN [0:15] = '{
        32'sh20000000, 32'sh12E4051E, 32'sh09FB385B, 32'sh051111D4,
        32'sh028B0D43, 32'sh0145D7E1, 32'sh00A2F61E, 32'sh00517C55,
        32'sh0028BE53, 32'sh00145F2F, 32'sh000A2F98, 32'sh000517CC,
        32'sh00028BE6, 32'sh000145F3, 32'sh0000A2FA, 32'sh0000517D
    };

    typedef enum logic [1:0] {IDLE, ROTATE, SCALE} state_t;

    state_t               state;
    logic [CW-1:0]        iter;

    logic signed [IW-1:0] x_p0;
    logic signed [IW-1:0] y_p0;
    logic signed [31:0]   z_p0;
    logic                 zero_p0;

    logic signed [IW-1:0] x_ext, y_ext;
    logic signed [IW-1:0] x_pre, y_pre;
    logic signed [31:0]   z_pre;
    logic signed [IW-1:0] x_sh, y_sh;
    logic signed [IW-1:0] x_nxt, y_nxt;
    logic signed [31:0]   z_nxt;

    // Beyond the table, atan(2^-i) ~ 2^-i rad, i.e. 2^32/(2*pi) >> i.
    function automatic logic signed [31:0] atan_lut(input logic [CW-1:0] idx);
        int k;
        k = int'(idx);
        if (k < 16)
            return ATAN[k[3:0]];
        else
            return 32'(32'd683565276 >> k);
    endfunction

    // Multiply by ~0.6074 (1/2 + 1/8 - 1/64 - 1/512) to undo the CORDIC gain.
    function automatic logic [WIDTH:0] gain_comp(input logic signed [IW-1:0] v);
        logic signed [IW-1:0] s;
        s = (v >>> 1) + (v >>> 3) - (v >>> 6) - (v >>> 9);
        return MW'(s);
    endfunction

    // Quadrant pre-rotation brings the vector into the right half-plane.
    always_comb begin
        x_ext = {{2{x_in[WIDTH-1]}}, x_in};
        y_ext = {{2{y_in[WIDTH-1]}}, y_in};
        x_pre = x_ext;
        y_pre = y_ext;
        z_pre = 32'sh00000000;
        if (x_in[WIDTH-1]) begin
            if (!y_in[WIDTH-1]) begin
                x_pre = y_ext;
                y_pre = -x_ext;
                z_pre = 32'sh40000000;
            end else begin
                x_pre = -y_ext;
                y_pre = x_ext;
                z_pre = 32'shC0000000;
            end
        end
    end

    always_comb begin
        x_sh = x_p0 >>> iter;
        y_sh = y_p0 >>> iter;
        if (!y_p0[IW-1]) begin
            x_nxt = x_p0 + y_sh;
            y_nxt = y_p0 - x_sh;
            z_nxt = z_p0 + atan_lut(iter);
        end else begin
            x_nxt = x_p0 - y_sh;
            y_nxt = y_p0 + x_sh;
            z_nxt = z_p0 - atan_lut(iter);
        end
    end

    // Stage 0: working vector registers, loaded on accept and stepped while rotating.
    always_ff @(posedge clk) begin
        if (state == IDLE && start) begin
            x_p0    <= x_pre;
            y_p0    <= y_pre;
            z_p0    <= z_pre;
            zero_p0 <= (x_in == '0) && (y_in == '0);
        end else if (state == ROTATE) begin
            x_p0 <= x_nxt;
            y_p0 <= y_nxt;
            z_p0 <= z_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            iter  <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            mag   <= '0;
            angle <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= ROTATE;
                        iter  <= '0;
                        busy  <= 1'b1;
                    end
                end
                ROTATE: begin
                    if (iter == CW'(ITERS - 1)) begin
                        state <= SCALE;
                        iter  <= '0;
                    end else begin
                        iter <= iter + 1'b1;
                    end
                end
                SCALE: begin
                    mag   <= zero_p0 ? '0 : gain_comp(x_p0);
                    angle <= zero_p0 ? '0 : z_p0;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_vectoring.sv
// Directed bench for cordic_vectoring: vector table plus handshake/reset sequences.
`timescale 1ns/1ps

module tb_cordic_vectoring;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               start = 1'b0;
    logic signed [15:0] x_in = '0;
    logic signed [15:0] y_in = '0;
    logic               busy;
    logic               done;
    logic [16:0]        mag;
    logic [31:0]        angle;

    int n_checks = 0;
    int n_errors = 0;

    cordic_vectoring #(.WIDTH(16), .ITERS(16)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .x_in  (x_in),
        .y_in  (y_in),
        .busy  (busy),
        .done  (done),
        .mag   (mag),
        .angle (angle)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic signed [15:0] x;
        logic signed [15:0] y;
        int                 mag;
        logic [31:0]        ang;
        bit                 exact;
    } vec_t;

    vec_t vecs [0:9];

    task automatic check(input string name, input bit pass, input longint act, input longint req);
        n_checks++;
        if (!pass) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    function automatic bit ang_ok(input logic [31:0] got, input logic [31:0] exp);
        logic signed [31:0] d;
        d = got - exp;
        if (d < 0) d = -d;
        return d <= 32'sh00130000;
    endfunction

    function automatic bit mag_ok(input int got, input int exp);
        int d;
        d = got - exp;
        if (d < 0) d = -d;
        return d * 100 <= exp + 200;
    endfunction

    // Issue one conversion; returns edges from accept to done (0 if it never came).
    task automatic do_conv(input logic signed [15:0] xv, input logic signed [15:0] yv,
                           output int lat);
        @(negedge clk);
        x_in  = xv;
        y_in  = yv;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("busy_after_accept", busy == 1'b1, longint'(busy), 1);
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = k;
                break;
            end
        end
    endtask

    initial begin
        int lat;
        int ndone;
        int t1, t2;
        bit stable;
        bit drained;
        logic [16:0] prev_mag;
        logic [31:0] prev_ang;
        logic [16:0] got_mag;
        logic [31:0] got_ang;

        vecs[0] = '{x:  16'sd200,   y:  16'sd200,   mag: 283,   ang: 32'h20000000, exact: 1'b0};
        vecs[1] = '{x:  16'sd1000,  y:  16'sd0,     mag: 1000,  ang: 32'h00000000, exact: 1'b0};
        vecs[2] = '{x:  16'sd0,     y:  16'sd1000,  mag: 1000,  ang: 32'h40000000, exact: 1'b0};
        vecs[3] = '{x: -16'sd1000,  y:  16'sd0,     mag: 1000,  ang: 32'h80000000, exact: 1'b0};
        vecs[4] = '{x: -16'sd1000,  y: -16'sd1000,  mag: 1414,  ang: 32'hA0000000, exact: 1'b0};
        vecs[5] = '{x: -16'sd32768, y: -16'sd32768, mag: 46341, ang: 32'hA0000000, exact: 1'b0};
        vecs[6] = '{x:  16'sd0,     y:  16'sd0,     mag: 0,     ang: 32'h00000000, exact: 1'b1};
        vecs[7] = '{x:  16'sd0,     y: -16'sd1000,  mag: 1000,  ang: 32'hC0000000, exact: 1'b0};
        vecs[8] = '{x:  16'sd3000,  y: -16'sd4000,  mag: 5000,  ang: 32'hDA37F5C5, exact: 1'b0};
        vecs[9] = '{x: -16'sd3000,  y:  16'sd4000,  mag: 5000,  ang: 32'h5A37F5C5, exact: 1'b0};

        repeat (3) @(posedge clk);
        #1;
        check("reset_busy",  busy == 1'b0,  longint'(busy),  0);
        check("reset_done",  done == 1'b0,  longint'(done),  0);
        check("reset_mag",   mag == '0,     longint'(mag),   0);
        check("reset_angle", angle == '0,   longint'(angle), 0);
        @(negedge clk);
        rst = 1'b0;

        for (int v = 0; v < 10; v++) begin
            do_conv(vecs[v].x, vecs[v].y, lat);
            check($sformatf("latency_%0d", v), lat == 17, lat, 17);
            if (vecs[v].exact) begin
                check($sformatf("mag_%0d", v), int'(mag) == vecs[v].mag, longint'(mag), vecs[v].mag);
                check($sformatf("angle_%0d", v), angle == vecs[v].ang, longint'(angle), longint'(vecs[v].ang));
            end else begin
                check($sformatf("mag_%0d", v), mag_ok(int'(mag), vecs[v].mag), longint'(mag), vecs[v].mag);
                check($sformatf("angle_%0d", v), ang_ok(angle, vecs[v].ang), longint'(angle), longint'(vecs[v].ang));
            end
            @(posedge clk);
            #1;
            check($sformatf("done_pulse_%0d", v), done == 1'b0, longint'(done), 0);
        end

        // Start pulses while busy must be ignored; outputs frozen until done.
        prev_mag = mag;
        prev_ang = angle;
        @(negedge clk);
        x_in  = 16'sd1000;
        y_in  = 16'sd0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        ndone  = 0;
        t1     = 0;
        stable = 1'b1;
        got_mag = '0;
        got_ang = '0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                ndone++;
                if (t1 == 0) t1 = k;
                got_mag = mag;
                got_ang = angle;
            end else if (busy && (mag != prev_mag || angle != prev_ang)) begin
                stable = 1'b0;
            end
            if (k == 4 || k == 9) begin
                x_in  = 16'sd0;
                y_in  = 16'sd1000;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        check("ignored_start_done_count", ndone == 1, ndone, 1);
        check("ignored_start_latency", t1 == 17, t1, 17);
        check("outputs_stable_while_busy", stable, longint'(stable), 1);
        check("ignored_start_angle", ang_ok(got_ang, 32'h00000000), longint'(got_ang), 0);
        check("ignored_start_mag", mag_ok(int'(got_mag), 1000), longint'(got_mag), 1000);

        // start held high: a result every 18 clocks.
        @(negedge clk);
        x_in  = 16'sd1000;
        y_in  = 16'sd0;
        start = 1'b1;
        @(posedge clk);
        #1;
        ndone = 0;
        t1 = 0;
        t2 = 0;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                ndone++;
                if (ndone == 1) t1 = k;
                if (ndone == 2) t2 = k;
            end
        end
        start = 1'b0;
        check("held_first_done", t1 == 17, t1, 17);
        check("held_interval", t2 - t1 == 18, t2 - t1, 18);
        check("held_done_count", ndone == 3, ndone, 3);
        drained = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (!busy) begin
                drained = 1'b1;
                break;
            end
        end
        check("held_drain", drained, longint'(drained), 1);

        // Reset while rotating (counter at 7) aborts with everything cleared.
        @(negedge clk);
        x_in  = 16'sd1000;
        y_in  = 16'sd1000;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("abort_busy",  busy == 1'b0, longint'(busy),  0);
        check("abort_done",  done == 1'b0, longint'(done),  0);
        check("abort_mag",   mag == '0,    longint'(mag),   0);
        check("abort_angle", angle == '0,  longint'(angle), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk);
            #1;
            if (done || busy) ndone++;
        end
        check("abort_no_done", ndone == 0, ndone, 0);

        do_conv(-16'sd1000, -16'sd1000, lat);
        check("post_reset_latency", lat == 17, lat, 17);
        check("post_reset_mag", mag_ok(int'(mag), 1414), longint'(mag), 1414);
        check("post_reset_angle", ang_ok(angle, 32'hA0000000), longint'(angle), longint'(32'hA0000000));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
